booth_r4_seq_mult: RTL and testbench
====================================

# booth_r4_seq_mult

Parametrised sequential radix-4 Booth multiplier with per-operand signed/unsigned mode and a start/busy/done handshake. It extends the 8-bit fixed-mode multiplier (signed multiplicand, unsigned multiplier, load-driven) to any even operand width W and to all four sign combinations. It retires one recoded partial product per clock into an internal accumulator. It is intended as the shared multiplier core for datapaths that cannot afford an array multiplier.

## Interface
- W, 8, operand width; must be even and ≥ 4
- clk  input  1  rising-edge clock; single clock domain
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- a_signed  input  1  1: a is two's complement; 0: a is unsigned
- b_signed  input  1  1: b is two's complement; 0: b is unsigned
- a  input  W  multiplicand
- b  input  W  multiplier
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; prod valid from this cycle
- prod  output  2W  product; held until the next completion

## Operation
- N = W/2 + 1 iterations per multiply (W=8 → 5, W=16 → 9).
- Capture on accepted start:
  - A = a extended to W+2 bits (sign extension if a_signed, zero extension otherwise).
  - B = b extended to W+2 bits by the same rule using b_signed, with an implicit bit B[-1]=0.
  - Accumulator cleared; iteration counter i=0.
- Recoding of triplet {B[2i+1],B[2i],B[2i-1]}:
  - 000/111 → 0
  - 001/010 → +A
  - 011 → +2A
  - 100 → −2A
  - 101/110 → −A
- Each RUN cycle adds the selected digit × A, sign-extended and shifted left by 2i, into a 2W+4-bit two's-complement accumulator. Subtraction is implemented as invert plus carry-in.
- States:
  - IDLE: busy=0. start=1 goes to RUN.
  - RUN: busy=1. After iteration N−1 goes to IDLE, loads prod ← acc[2W−1:0] and pulses done.
- Result width rule:
  - prod is the exact product in 2W bits for all four modes.
  - prod reads as signed if a_signed|b_signed, otherwise as unsigned.
  - No overflow is possible.
- Mode and operand inputs are registered at start. Changes during busy have no effect.
- start while busy=1 is ignored and not queued.
- start in the done cycle is accepted, because the block is already in IDLE.
- The prod register changes only at completion. It is not cleared by start.

## Timing
- Reset values: busy=0, done=0, prod=0, state=IDLE, accumulator=0, counter=0.
- start high before edge k (idle) → busy=1 after edge k.
- Iterations execute on edges k+1 … k+N.
- After edge k+N: busy=0, done=1 for exactly one cycle, prod valid.
- Latency: N+1 edges from the start edge to done. Throughput: one multiply per N+1 cycles with back-to-back starts.
- rst=1 at any edge, including mid-RUN, aborts the operation and restores the reset values. No done is issued for the aborted operation.
- rst and start high on the same edge: reset wins and the start is dropped.

## Test plan
- W=8, a_signed=1, b_signed=0, a=8'h80, b=8'hFF → done 6 edges after start, prod=16'h8080 (−32640). busy is high for exactly 5 cycles.
- W=8, all four modes with a=b=8'hFF:
  - uu → 16'hFE01
  - su → 16'hFF01 (−255)
  - us → 16'hFF01
  - ss → 16'h0001
- W=8, ss with a=b=8'h80 → 16'h4000. ss with a=b=8'h7F → 16'h3F01.
- W=8, start asserted with a=3, b=5, then start re-pulsed and operands changed mid-RUN → those are ignored, prod=16'h000F. A new start in the done cycle is accepted with busy=1 the next cycle.
- W=8, rst asserted on the 3rd RUN cycle → busy=0, done never pulses, prod=0. The next start with a=2, b=7 (uu) gives prod=16'h000E.
- W=16, su with a=16'h8000, b=16'hFFFF → prod=32'h80008000 after 10 edges. Random regression over all modes is checked against a reference model.

Source files
------------

// File: rtl/booth_r4_seq_mult.sv
// booth_r4_seq_mult: sequential radix-4 Booth multiplier, one recoded partial product per clock, per-operand sign mode
module booth_r4_seq_mult #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           a_signed,
  input  logic           b_signed,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] prod
);
  localparam int N  = W / 2 + 1;
  localparam int CW = $clog2(N);
  typedef enum logic {IDLE, RUN} state_t;
  state_t         state;
  logic [2*W+3:0] a_sh, acc, op, sum;
  logic [W+2:0]   b_sh;
  logic [CW-1:0]  cnt;
  logic [2:0]     t;
  logic           neg;
  assign busy = (state == RUN);
  always_comb begin
    t   = b_sh[2:0];
    neg = t[2] & ~(t[1] & t[0]);
    op  = (t == 3'b000 || t == 3'b111) ? '0 : (t == 3'b011 || t == 3'b100) ? a_sh << 1 : a_sh;
    sum = acc + (neg ? ~op : op) + {{(2*W+3){1'b0}}, neg};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
      prod  <= '0;
      acc   <= '0;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state <= RUN;
          a_sh  <= {{(W+4){a_signed & a[W-1]}}, a};
          b_sh  <= {{2{b_signed & b[W-1]}}, b, 1'b0};
          acc   <= '0;
          cnt   <= '0;
        end
      end else begin
        acc  <= sum;
        a_sh <= a_sh << 2;
        b_sh <= b_sh >> 2;
        cnt  <= (cnt == CW'(N-1)) ? '0 : cnt + 1'b1;
        if (cnt == CW'(N-1)) begin
          state <= IDLE;
          done  <= 1'b1;
          prod  <= sum[2*W-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// tb_booth_r4_seq_mult: randomized self-checking bench for booth_r4_seq_mult at W=8 and W=16
module tb_booth_r4_seq_mult;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic st8 = 1'b0, as8 = 1'b0, bs8 = 1'b0, busy8, done8;
  logic [7:0] a8 = '0, b8 = '0;
  logic [15:0] prod8;
  logic st16 = 1'b0, as16 = 1'b0, bs16 = 1'b0, busy16, done16;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] prod16;
  int total = 0;
  int bad = 0;
  booth_r4_seq_mult #(.W(8)) u8 (
    .clk(clk), .rst(rst), .start(st8), .a_signed(as8), .b_signed(bs8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .prod(prod8)
  );
  booth_r4_seq_mult #(.W(16)) u16 (
    .clk(clk), .rst(rst), .start(st16), .a_signed(as16), .b_signed(bs16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .prod(prod16)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] x, input logic [31:0] y,
                                          input logic xs, input logic ys);
    longint vx, vy;
    logic [63:0] p, m;
    vx = (xs && x[w-1]) ? longint'(x) - (longint'(1) << w) : longint'(x);
    vy = (ys && y[w-1]) ? longint'(y) - (longint'(1) << w) : longint'(y);
    p  = vx * vy;
    m  = (64'd1 << (2 * w)) - 64'd1;
    return p & m;
  endfunction
  task automatic mul8(input logic [7:0] x, input logic [7:0] y, input logic xs, input logic ys,
                      output logic [15:0] p, output int lat, output int bc);
    @(negedge clk);
    a8 = x; b8 = y; as8 = xs; bs8 = ys; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    lat = 1;
    bc = 0;
    while (!done8 && lat < 50) begin
      bc += int'(busy8);
      @(negedge clk);
      lat++;
    end
    p = prod8;
  endtask
  task automatic mul16(input logic [15:0] x, input logic [15:0] y, input logic xs, input logic ys,
                       output logic [31:0] p, output int lat);
    @(negedge clk);
    a16 = x; b16 = y; as16 = xs; bs16 = ys; st16 = 1'b1;
    @(negedge clk);
    st16 = 1'b0;
    lat = 1;
    while (!done16 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    p = prod16;
  endtask
  initial begin
    logic [15:0] p8;
    logic [31:0] p16;
    int lat, bc;
    bit seen;
    logic [7:0] ra, rb;
    logic [15:0] sa, sb;
    logic rs, rt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_done", 64'(done8), 64'd0);
    chk("rst_prod", 64'(prod8), 64'd0);
    chk("rst_prod16", 64'(prod16), 64'd0);
    mul8(8'h80, 8'hFF, 1'b1, 1'b0, p8, lat, bc);
    chk("su80FF_prod", 64'(p8), 64'h8080);
    chk("su80FF_lat", 64'(lat), 64'd6);
    chk("su80FF_busy", 64'(bc), 64'd5);
    @(negedge clk);
    chk("done_one_cycle", 64'(done8), 64'd0);
    repeat (3) @(negedge clk);
    chk("prod_held", 64'(prod8), 64'h8080);
    mul8(8'hFF, 8'hFF, 1'b0, 1'b0, p8, lat, bc);
    chk("uuFF", 64'(p8), 64'hFE01);
    mul8(8'hFF, 8'hFF, 1'b1, 1'b0, p8, lat, bc);
    chk("suFF", 64'(p8), 64'hFF01);
    mul8(8'hFF, 8'hFF, 1'b0, 1'b1, p8, lat, bc);
    chk("usFF", 64'(p8), 64'hFF01);
    mul8(8'hFF, 8'hFF, 1'b1, 1'b1, p8, lat, bc);
    chk("ssFF", 64'(p8), 64'h0001);
    mul8(8'h80, 8'h80, 1'b1, 1'b1, p8, lat, bc);
    chk("ss80", 64'(p8), 64'h4000);
    mul8(8'h7F, 8'h7F, 1'b1, 1'b1, p8, lat, bc);
    chk("ss7F", 64'(p8), 64'h3F01);
    @(negedge clk);
    a8 = 8'd3; b8 = 8'd5; as8 = 1'b0; bs8 = 1'b0; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    @(negedge clk);
    a8 = 8'hA5; b8 = 8'h5A; as8 = 1'b1; bs8 = 1'b1; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("midrun_ignore", 64'(prod8), 64'h000F);
    a8 = 8'd2; b8 = 8'd2; as8 = 1'b0; bs8 = 1'b0; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    chk("start_in_done", 64'(busy8), 64'd1);
    lat = 0;
    while (!done8 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("start_in_done_prod", 64'(prod8), 64'h0004);
    @(negedge clk);
    a8 = 8'd9; b8 = 8'd9; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy8), 64'd0);
    chk("abort_prod", 64'(prod8), 64'd0);
    seen = 1'b0;
    repeat (8) begin
      seen |= done8;
      @(negedge clk);
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    mul8(8'd2, 8'd7, 1'b0, 1'b0, p8, lat, bc);
    chk("after_abort", 64'(p8), 64'h000E);
    mul16(16'h8000, 16'hFFFF, 1'b1, 1'b0, p16, lat);
    chk("w16_su_prod", 64'(p16), 64'h80008000);
    chk("w16_su_lat", 64'(lat), 64'd10);
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rs = 1'($urandom); rt = 1'($urandom);
      mul8(ra, rb, rs, rt, p8, lat, bc);
      chk($sformatf("rnd8_%0d", i), 64'(p8), ref_mul(8, 32'(ra), 32'(rb), rs, rt));
      sa = 16'($urandom); sb = 16'($urandom);
      rs = 1'($urandom); rt = 1'($urandom);
      mul16(sa, sb, rs, rt, p16, lat);
      chk($sformatf("rnd16_%0d", i), 64'(p16), ref_mul(16, 32'(sa), 32'(sb), rs, rt));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
